float_to_fixed: RTL and testbench
=================================

Name: float_to_fixed

Overview:
- Pipelined IEEE-754-style floating-point to signed fixed-point converter; inverse of the team's fixed-to-float block, used to bring float results back into the integer datapath.
- Accepts one float word per clock with a valid strobe.
- Returns a rounded, saturated two's-complement value with status flags after a fixed 3-cycle latency.
- No backpressure.

Parameters:
FIXED_WIDTH, 12, width of signed fixed-point output q (2..32)
FRAC_BITS, 0, fractional bits in q (0..FIXED_WIDTH-1); q represents value*2^FRAC_BITS
EXP_WIDTH, 8, float exponent width; bias = 2^(EXP_WIDTH-1)-1
MANT_WIDTH, 23, float stored mantissa width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset
in_valid  in  1  a is valid this cycle
a  in  EXP_WIDTH+MANT_WIDTH+1  float input {sign, exp, mant}
out_valid  out  1  q/ovf/inv valid this cycle
q  out  FIXED_WIDTH  signed fixed-point result
ovf  out  1  result saturated (overflow or infinity)
inv  out  1  input was NaN

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. On reset, all pipeline valid bits clear; out_valid=0, q=0, ovf=0, inv=0.
- Reset mid-stream: in-flight samples are discarded. After release, the first out_valid occurs exactly 3 cycles after the first accepted in_valid.
- Latency: in_valid high at rising edge N gives out_valid high after edge N+3, for exactly one cycle per input.
- Throughput: one sample per clock. Gaps in in_valid propagate as gaps in out_valid.
- Invalid-cycle outputs: when out_valid=0, q/ovf/inv hold their last values. Data registers load only when the stage valid bit is set.
- Decode:
  - s = a[MSB], e = exponent field, m = mantissa field.
  - Effective exponent k = e - bias + FRAC_BITS, signed, computed with width EXP_WIDTH+2.
- Classes (resolved in stage 1):
  - e=0 (zero or denormal): flush, q=0, ovf=0, inv=0.
  - e=all-ones, m!=0 (NaN): q=0, inv=1, ovf=0.
  - e=all-ones, m=0 (infinity): saturate to the signed limit, ovf=1.
  - Otherwise normal, magnitude M = 1.m * 2^k.
- Stage 1: register s, class flags, k, and {1,m}.
- Stage 2: align.
  - k >= FIXED_WIDTH: early-overflow flag set.
  - k < -1: aligned magnitude = 0, round bit = 0.
  - Else: integer part = floor(M), width FIXED_WIDTH+1; round bit = first bit below the integer LSB. Bits beyond are ignored.
- Stage 3: round, sign, saturate.
  - Rounding is round-half-away-from-zero on magnitude: R = int + round bit.
  - Positive: if R > 2^(FIXED_WIDTH-1)-1 or early-overflow, q = 2^(FIXED_WIDTH-1)-1 and ovf=1.
  - Negative: if R > 2^(FIXED_WIDTH-1) or early-overflow, q = -2^(FIXED_WIDTH-1) and ovf=1. R = 2^(FIXED_WIDTH-1) exactly gives the most negative value with ovf=0.
  - Otherwise q = s ? -R : R.
  - -0.0 and values rounding to 0 produce q=0, never a negative zero; ovf=0.
- Flags: ovf and inv are mutually exclusive and are qualified by out_valid.

Test Plan:
- FIXED_WIDTH=12, FRAC_BITS=0, single pulse: in_valid with a=0x3F800000 (1.0) at edge N -> out_valid only after edge N+3, q=1, ovf=0, inv=0.
- Saturation boundaries:
  - 0xC5000000 (-2048.0) -> q=0x800, ovf=0.
  - 0x45000000 (2048.0) -> q=0x7FF, ovf=1.
  - 0xC5000800 (-2048.5) -> q=0x800, ovf=1.
  - 0xC4FFF000 (-2047.5) -> q=0x800, ovf=0.
- Rounding:
  - 0x40200000 (2.5) -> 3.
  - 0xC0200000 (-2.5) -> -3.
  - 0x3F000000 (0.5) -> 1.
  - 0x3ECCCCCD (0.4) -> 0.
  - 0x80000000 (-0.0) -> 0.
- Specials:
  - 0x7F800000 -> q=0x7FF, ovf=1.
  - 0xFF800000 -> q=0x800, ovf=1.
  - 0x7FC00000 -> q=0, inv=1.
  - 0x00000001 (denormal) -> q=0, both flags 0.
- FRAC_BITS=4: 0x3FC00000 (1.5) -> q=24. 0x3D000000 (0.03125) -> q=1, from rounding 0.5 LSB away from zero.
- Streaming and reset:
  - 20 back-to-back random normals, then an in_valid pattern 1,0,1,1: outputs match the reference model in order, with the same valid pattern delayed 3 cycles.
  - Assert rst_n low with 2 samples in flight: out_valid=0 immediately. After release no stale out_valid appears; the next input gives output at +3.

Source files
------------

// File: rtl/float_to_fixed.sv
// Pipelined float-to-signed-fixed converter: an input register, then decode, align and round/saturate stages.
// The output is rounded half away from zero and saturated. Latency is 3 cycles after the input is sampled.
module float_to_fixed #(
  parameter int FIXED_WIDTH = 12,
  parameter int FRAC_BITS   = 0,
  parameter int EXP_WIDTH   = 8,
  parameter int MANT_WIDTH  = 23
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  input  logic [EXP_WIDTH+MANT_WIDTH:0]   a,
  output logic                            out_valid,
  output logic [FIXED_WIDTH-1:0]          q,
  output logic                            ovf,
  output logic                            inv
);

  localparam int AW   = EXP_WIDTH + MANT_WIDTH + 1;
  localparam int KW   = EXP_WIDTH + 2;
  localparam int BIAS = (1 << (EXP_WIDTH - 1)) - 1;
  localparam int SW   = MANT_WIDTH + FIXED_WIDTH + 2;

  localparam logic signed [KW-1:0]    K_LIMIT   = KW'(FIXED_WIDTH);
  localparam logic signed [KW-1:0]    K_NEG_ONE = '1;
  localparam logic [FIXED_WIDTH:0]    POS_MAX   = (FIXED_WIDTH+1)'((64'd1 << (FIXED_WIDTH - 1)) - 64'd1);
  localparam logic [FIXED_WIDTH:0]    NEG_MAG   = (FIXED_WIDTH+1)'(64'd1 << (FIXED_WIDTH - 1));
  localparam logic [FIXED_WIDTH-1:0]  Q_POS     = {1'b0, {(FIXED_WIDTH-1){1'b1}}};
  localparam logic [FIXED_WIDTH-1:0]  Q_NEG     = {1'b1, {(FIXED_WIDTH-1){1'b0}}};

  logic                   in_v_r;
  logic [AW-1:0]          a_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_v_r <= 1'b0;
      a_r    <= '0;
    end else begin
      in_v_r <= in_valid;
      if (in_valid) a_r <= a;
    end
  end

  logic [EXP_WIDTH-1:0]   exp_d;
  logic [MANT_WIDTH-1:0]  mant_d;
  logic [KW-1:0]          k_d;

  assign exp_d  = a_r[AW-2:MANT_WIDTH];
  assign mant_d = a_r[MANT_WIDTH-1:0];
  assign k_d    = KW'(exp_d) - KW'(BIAS) + KW'(FRAC_BITS);

  logic                   s1_valid, s1_sign, s1_zero, s1_nan, s1_inf;
  logic signed [KW-1:0]   s1_k;
  logic [MANT_WIDTH:0]    s1_mant;

  // Stage 1: classify the float and keep the effective exponent with the hidden-bit mantissa.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_nan   <= 1'b0;
      s1_inf   <= 1'b0;
      s1_k     <= '0;
      s1_mant  <= '0;
    end else begin
      s1_valid <= in_v_r;
      if (in_v_r) begin
        s1_sign  <= a_r[AW-1];
        s1_zero  <= (exp_d == '0);
        s1_nan   <= (&exp_d) && (mant_d != '0);
        s1_inf   <= (&exp_d) && (mant_d == '0);
        s1_k     <= k_d;
        s1_mant  <= {1'b1, mant_d};
      end
    end
  end

  logic [KW-1:0]          shamt;
  logic [FIXED_WIDTH+1:0] aligned_top;
  logic [FIXED_WIDTH:0]   int_d;
  logic                   rnd_d, sat_d;

  // Shifting by k+1 leaves MANT_WIDTH+1 fraction bits, so the integer part and round bit sit directly above.
  assign shamt       = s1_k + KW'(1);
  assign aligned_top = (FIXED_WIDTH+2)'((SW'(s1_mant) << shamt) >> MANT_WIDTH);

  always_comb begin
    int_d = '0;
    rnd_d = 1'b0;
    sat_d = 1'b0;
    if (s1_inf) begin
      sat_d = 1'b1;
    end else if (!s1_zero && !s1_nan) begin
      if (s1_k >= K_LIMIT) begin
        sat_d = 1'b1;
      end else if (s1_k >= K_NEG_ONE) begin
        int_d = aligned_top[FIXED_WIDTH+1:1];
        rnd_d = aligned_top[0];
      end
    end
  end

  logic                   s2_valid, s2_sign, s2_nan, s2_sat, s2_rnd;
  logic [FIXED_WIDTH:0]   s2_int;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_nan   <= 1'b0;
      s2_sat   <= 1'b0;
      s2_rnd   <= 1'b0;
      s2_int   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign <= s1_sign;
        s2_nan  <= s1_nan;
        s2_sat  <= sat_d;
        s2_rnd  <= rnd_d;
        s2_int  <= int_d;
      end
    end
  end

  logic [FIXED_WIDTH:0]   rounded, rounded_neg;
  logic [FIXED_WIDTH-1:0] q_d;
  logic                   ovf_d;

  assign rounded     = s2_int + (FIXED_WIDTH+1)'(s2_rnd);
  assign rounded_neg = -rounded;

  // The negative range reaches one step further, so -2^(FIXED_WIDTH-1) is exact and not flagged.
  always_comb begin
    q_d   = '0;
    ovf_d = 1'b0;
    if (!s2_nan) begin
      if (!s2_sign) begin
        if (s2_sat || rounded > POS_MAX) begin
          q_d   = Q_POS;
          ovf_d = 1'b1;
        end else begin
          q_d = rounded[FIXED_WIDTH-1:0];
        end
      end else begin
        if (s2_sat || rounded > NEG_MAG) begin
          q_d   = Q_NEG;
          ovf_d = 1'b1;
        end else begin
          q_d = rounded_neg[FIXED_WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      q         <= '0;
      ovf       <= 1'b0;
      inv       <= 1'b0;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        q   <= q_d;
        ovf <= ovf_d;
        inv <= s2_nan;
      end
    end
  end

endmodule

// File: tb/tb_float_to_fixed.sv
// Scoreboard bench for float_to_fixed with FRAC_BITS=0 and FRAC_BITS=4 instances driven by the same stream.
// An integer reference model predicts the results; output cycles and held values are checked every cycle.
module tb_float_to_fixed;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic        ov0, ov4, ovf0, ovf4, inv0, inv4;
  logic [11:0] q0, q4;

  always #5 clk = ~clk;

  float_to_fixed #(.FIXED_WIDTH(12), .FRAC_BITS(0), .EXP_WIDTH(8), .MANT_WIDTH(23)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a),
    .out_valid(ov0), .q(q0), .ovf(ovf0), .inv(inv0)
  );

  float_to_fixed #(.FIXED_WIDTH(12), .FRAC_BITS(4), .EXP_WIDTH(8), .MANT_WIDTH(23)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a),
    .out_valid(ov4), .q(q4), .ovf(ovf4), .inv(inv4)
  );

  typedef struct {
    logic [13:0] exp0;
    logic [13:0] exp4;
    int          due;
  } sb_entry_t;

  sb_entry_t   sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [13:0] last0 = '0;
  logic [13:0] last4 = '0;
  bit          mon_v;
  sb_entry_t   mon_e;

  logic [31:0] directed [16] = '{
    32'h3F800000, 32'hC5000000, 32'h45000000, 32'hC5000800,
    32'hC4FFF000, 32'h40200000, 32'hC0200000, 32'h3F000000,
    32'h3ECCCCCD, 32'h80000000, 32'h7F800000, 32'hFF800000,
    32'h7FC00000, 32'h00000001, 32'h3FC00000, 32'h3D000000
  };

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", tag, act, exp, cyc);
    end
  endtask

  // Result packed as {inv, ovf, q[11:0]}
  function automatic logic [13:0] model(input logic [31:0] f, input int frac);
    int          e, sh;
    longint      mant, mag;
    logic [11:0] qv;
    e    = int'(f[30:23]);
    mant = longint'({1'b1, f[22:0]});
    if (e == 0) return 14'h0;
    if (e == 255) begin
      if (f[22:0] != 23'd0) return {2'b10, 12'h000};
      return f[31] ? {2'b01, 12'h800} : {2'b01, 12'h7FF};
    end
    sh = e - 127 + frac - 23;
    if (sh >= 20)      mag = longint'(1) << 40;
    else if (sh >= 0)  mag = mant << sh;
    else if (sh < -40) mag = 0;
    else               mag = (mant + (longint'(1) << (-sh - 1))) >> (-sh);
    if (!f[31]) begin
      if (mag > 2047) return {2'b01, 12'h7FF};
      qv = 12'(mag);
    end else begin
      if (mag > 2048) return {2'b01, 12'h800};
      qv = 12'(-mag);
    end
    return {2'b00, qv};
  endfunction

  function automatic logic [31:0] rand_normal();
    logic [31:0] w;
    w[31]    = 1'($urandom_range(0, 1));
    w[30:23] = 8'($urandom_range(118, 139));
    w[22:0]  = 23'($urandom);
    return w;
  endfunction

  task automatic applyStimulus(input bit v, input logic [31:0] word);
    sb_entry_t e;
    @(negedge clk);
    in_valid = v;
    a        = word;
    if (v) begin
      e.exp0 = model(word, 0);
      e.exp4 = model(word, 4);
      e.due  = cyc + 4;
      sb.push_back(e);
    end
  endtask

  task automatic checkResetState();
    checkOutput("rst_valid0", 32'(ov0), 32'd0);
    checkOutput("rst_q0", 32'(q0), 32'd0);
    checkOutput("rst_ovf0", 32'(ovf0), 32'd0);
    checkOutput("rst_inv0", 32'(inv0), 32'd0);
    checkOutput("rst_valid4", 32'(ov4), 32'd0);
    checkOutput("rst_q4", 32'(q4), 32'd0);
  endtask

  // Every cycle: out_valid must match the scoreboard's due cycle; otherwise outputs must hold.
  always @(negedge clk) begin
    if (rst_n) begin
      mon_v = (sb.size() > 0) && (sb[0].due == cyc);
      checkOutput("valid0", 32'(ov0), 32'(mon_v));
      checkOutput("valid4", 32'(ov4), 32'(mon_v));
      if (mon_v) begin
        mon_e = sb.pop_front();
        last0 = mon_e.exp0;
        last4 = mon_e.exp4;
      end
      checkOutput(mon_v ? "q0" : "hold_q0", 32'(q0), 32'(last0[11:0]));
      checkOutput(mon_v ? "ovf0" : "hold_ovf0", 32'(ovf0), 32'(last0[12]));
      checkOutput(mon_v ? "inv0" : "hold_inv0", 32'(inv0), 32'(last0[13]));
      checkOutput(mon_v ? "q4" : "hold_q4", 32'(q4), 32'(last4[11:0]));
      checkOutput(mon_v ? "ovf4" : "hold_ovf4", 32'(ovf4), 32'(last4[12]));
      checkOutput(mon_v ? "inv4" : "hold_inv4", 32'(inv4), 32'(last4[13]));
    end
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    #1;
    checkResetState();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    applyStimulus(1'b1, 32'h3F800000);
    repeat (5) applyStimulus(1'b0, 32'hDEADBEEF);

    foreach (directed[i]) applyStimulus(1'b1, directed[i]);
    repeat (4) applyStimulus(1'b0, 32'h12345678);

    repeat (20) applyStimulus(1'b1, rand_normal());
    applyStimulus(1'b1, rand_normal());
    applyStimulus(1'b0, rand_normal());
    applyStimulus(1'b1, rand_normal());
    applyStimulus(1'b1, rand_normal());
    repeat (6) applyStimulus(1'b0, 32'h0);

    repeat (4) applyStimulus(1'b1, rand_normal());
    applyStimulus(1'b0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    checkResetState();
    sb.delete();
    last0 = '0;
    last4 = '0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (6) applyStimulus(1'b0, 32'h0);
    applyStimulus(1'b1, 32'h40200000);
    applyStimulus(1'b0, 32'h0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    checkOutput("drain", 32'(sb.size()), 32'd0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
